// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, writeback request type and error flag positions
package riscv_pkg;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);
    localparam int ERR_SPURIOUS_RETIRE = 0;
    localparam int ERR_WAW             = 1;
    localparam int ERR_STARVE          = 2;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback request, decode query and register file write bundle
interface regfile_wb_arbiter_if;
    import riscv_pkg::*;
    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              alu_ready;
    logic              ld_valid;
    logic [REG_AW-1:0] ld_rd;
    logic [XLEN-1:0]   ld_data;
    logic              ld_ready;
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rd;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              rs1_fwd;
    logic              rs2_fwd;
    logic              rf_wr_en;
    logic [REG_AW-1:0] rf_wr_addr;
    logic [XLEN-1:0]   rf_wr_data;
    logic [7:0]        err_vec;
    modport slave (
        input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        input  issue_valid, issue_rd, rs1_addr, rs2_addr,
        output alu_ready, ld_ready, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
        output rf_wr_en, rf_wr_addr, rf_wr_data, err_vec
    );
    modport master (
        output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
        output issue_valid, issue_rd, rs1_addr, rs2_addr,
        input  alu_ready, ld_ready, rs1_busy, rs2_busy, rs1_fwd, rs2_fwd,
        input  rf_wr_en, rf_wr_addr, rf_wr_data, err_vec
    );
endinterface

// File: rtl/wb_skid_buf.sv
// wb_skid_buf: one-entry holding register; refills in the same cycle it is popped
module wb_skid_buf
    import riscv_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  wb_req_t in_req,
    output logic    in_ready,
    output logic    out_valid,
    output wb_req_t out_req,
    input  logic    pop
);
    assign in_ready = !out_valid | pop;
    // load on accept, otherwise empty when popped
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_req   <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_req   <= in_req;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: buffers ALU/load writebacks, round-robin grants one write per cycle, tracks pending writes
module regfile_wb_arbiter
    import riscv_pkg::*;
#(
    parameter bit LD_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    regfile_wb_arbiter_if.slave bus
);
    logic             alu_v, ld_v, grant_alu, grant_ld, wr_en, rr_ld;
    logic             alu_starve, ld_starve, waw, spurious;
    logic [3:0]       alu_wait, ld_wait;
    logic [NREGS-1:0] busy, busy_nxt;
    logic [7:0]       err;
    wb_req_t          alu_in, ld_in, alu_q, ld_q, win;

    assign alu_in = '{rd: bus.alu_rd, data: bus.alu_data};
    assign ld_in  = '{rd: bus.ld_rd, data: bus.ld_data};

    wb_skid_buf u_alu_buf (
        .clk(clk), .rst(rst), .in_valid(bus.alu_valid), .in_req(alu_in), .in_ready(bus.alu_ready),
        .out_valid(alu_v), .out_req(alu_q), .pop(grant_alu)
    );
    wb_skid_buf u_ld_buf (
        .clk(clk), .rst(rst), .in_valid(bus.ld_valid), .in_req(ld_in), .in_ready(bus.ld_ready),
        .out_valid(ld_v), .out_req(ld_q), .pop(grant_ld)
    );

    // grant, write port, queries, next scoreboard and error conditions
    always_comb begin
        grant_ld   = ld_v & (!alu_v | rr_ld);
        grant_alu  = alu_v & (!ld_v | !rr_ld);
        win        = grant_ld ? ld_q : alu_q;
        wr_en      = (grant_ld | grant_alu) & (win.rd != '0);
        spurious   = wr_en & !busy[win.rd];
        waw        = bus.issue_valid & (bus.issue_rd != '0) & busy[bus.issue_rd] &
                     !(wr_en & (win.rd == bus.issue_rd));
        alu_starve = alu_v & !grant_alu & (alu_wait == 4'd15);
        ld_starve  = ld_v & !grant_ld & (ld_wait == 4'd15);
        busy_nxt   = busy;
        if (wr_en) busy_nxt[win.rd] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign bus.rf_wr_en   = wr_en;
    assign bus.rf_wr_addr = wr_en ? win.rd : '0;
    assign bus.rf_wr_data = wr_en ? win.data : '0;
    assign bus.rs1_fwd    = wr_en & (bus.rs1_addr == win.rd) & (bus.rs1_addr != '0);
    assign bus.rs2_fwd    = wr_en & (bus.rs2_addr == win.rd) & (bus.rs2_addr != '0);
    assign bus.rs1_busy   = busy[bus.rs1_addr] & !bus.rs1_fwd;
    assign bus.rs2_busy   = busy[bus.rs2_addr] & !bus.rs2_fwd;
    assign bus.err_vec    = err;

    // pointer flips only on contention; wait counters saturate; errors are sticky
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ld    <= LD_FIRST;
            busy     <= '0;
            err      <= '0;
            alu_wait <= '0;
            ld_wait  <= '0;
        end else begin
            rr_ld    <= (alu_v & ld_v) ? !rr_ld : rr_ld;
            busy     <= busy_nxt;
            alu_wait <= (alu_v & !grant_alu) ? alu_wait + {3'b0, alu_wait != 4'd15} : 4'd0;
            ld_wait  <= (ld_v & !grant_ld) ? ld_wait + {3'b0, ld_wait != 4'd15} : 4'd0;
            err[ERR_SPURIOUS_RETIRE] <= err[ERR_SPURIOUS_RETIRE] | spurious;
            err[ERR_WAW]             <= err[ERR_WAW] | waw;
            err[ERR_STARVE]          <= err[ERR_STARVE] | alu_starve | ld_starve;
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: per-cycle directed vectors plus a mid-operation reset sequence
module tb_regfile_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    regfile_wb_arbiter_if bus();
    regfile_wb_arbiter #(.LD_FIRST(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic av; logic [4:0] ard; logic [31:0] adat;
        logic lv; logic [4:0] lrd; logic [31:0] ldat;
        logic iv; logic [4:0] ird; logic [4:0] rs1; logic [4:0] rs2;
        logic ar; logic lr; logic we; logic [4:0] wa; logic [31:0] wd;
        logic b1; logic f1; logic b2; logic f2; logic [7:0] err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t idle_vec();
        vec_t v;
        v = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
              1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.alu_valid   = v.av;  bus.alu_rd = v.ard; bus.alu_data = v.adat;
        bus.ld_valid    = v.lv;  bus.ld_rd  = v.lrd; bus.ld_data  = v.ldat;
        bus.issue_valid = v.iv;  bus.issue_rd = v.ird;
        bus.rs1_addr    = v.rs1; bus.rs2_addr = v.rs2;
    endtask

    task automatic check(input string name, input vec_t v);
        logic [51:0] got, exp;
        got = {bus.alu_ready, bus.ld_ready, bus.rf_wr_en, bus.rf_wr_addr, bus.rf_wr_data,
               bus.rs1_busy, bus.rs1_fwd, bus.rs2_busy, bus.rs2_fwd, bus.err_vec};
        exp = {v.ar, v.lr, v.we, v.wa, v.wd, v.b1, v.f1, v.b2, v.f2, v.err};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got {ar,lr,we,wa,wd,b1,f1,b2,f2,err}=%h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        drive(v);
        @(negedge clk);
        check(name, v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        // av ard adat lv lrd ldat iv ird rs1 rs2 | ar lr we wa wd b1 f1 b2 f2 err
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd5,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b1,5'd5,32'hDEADBEEF,1'b0,5'd0,32'h0,1'b0,5'd0,5'd5,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd5,5'd0, 1'b1,1'b1,1'b1,5'd5,32'hDEADBEEF,1'b0,1'b1,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd5,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd3,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b1,5'd4,32'h22,1'b1,5'd3,32'h11,1'b1,5'd4,5'd3,5'd4, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd3,5'd4, 1'b0,1'b1,1'b1,5'd3,32'h11,1'b0,1'b1,1'b1,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd3,5'd4, 1'b1,1'b1,1'b1,5'd4,32'h22,1'b0,1'b0,1'b0,1'b1,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd10,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b1,5'd10,32'hA,1'b1,5'd11,32'hB,1'b1,5'd11,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b0,1'b1,5'd10,32'hA,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b1,5'd11,32'hB,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd7,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b1,5'd7,32'h77,1'b0,5'd0,32'h0,1'b0,5'd0,5'd7,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd7,5'd0, 1'b1,1'b1,1'b1,5'd7,32'h77,1'b0,1'b1,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd7,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b1,5'd0,32'h55,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd9,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b1,5'd9,32'h99,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd9,5'd0,5'd0, 1'b1,1'b1,1'b1,5'd9,32'h99,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd9,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b1,5'd12,32'hC,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b1,5'd12,32'hC,1'b0,1'b0,1'b0,1'b0,8'h0});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h1});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd6,5'd0,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b0,1'b0,8'h1});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b1,5'd6,5'd6,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0,1'b0,8'h1});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd6,5'd0, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b1,1'b0,1'b0,1'b0,8'h3});
        vq.push_back('{1'b1,5'd9,32'h1,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd9, 1'b1,1'b1,1'b0,5'd0,32'h0,1'b0,1'b0,1'b1,1'b0,8'h3});
        vq.push_back('{1'b1,5'd9,32'h2,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd9, 1'b1,1'b1,1'b1,5'd9,32'h1,1'b0,1'b0,1'b0,1'b1,8'h3});
        vq.push_back('{1'b0,5'd0,32'h0,1'b0,5'd0,32'h0,1'b0,5'd0,5'd0,5'd9, 1'b1,1'b1,1'b1,5'd9,32'h2,1'b0,1'b0,1'b0,1'b1,8'h3});

        drive(idle_vec());
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_held", idle_vec());
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vq[i]) step($sformatf("vec%0d", i), vq[i]);

        // fill both buffers, then reset while they still hold requests
        v = idle_vec();
        v.av = 1'b1; v.ard = 5'd13; v.adat = 32'hD1;
        v.lv = 1'b1; v.lrd = 5'd14; v.ldat = 32'hD2;
        drive(v);
        @(posedge clk);
        #1;
        drive(idle_vec());
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        v = idle_vec();
        v.rs1 = 5'd6;
        v.rs2 = 5'd9;
        step("after_rst", v);
        step("after_rst_next", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
